// File: rtl/aes_wddl_pkg.sv
// Shared definitions for the WDDL inverse AddRoundKey datapath:
// block width, round count, FSM encoding and a dual-rail validity check.
package aes_wddl_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;

  localparam logic [3:0] KCNT_IDLE  = 4'(NR);
  localparam logic [3:0] KCNT_FIRST = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    EVAL,
    DONE
  } state_e;

  // A rail pair is invalid when both rails agree (00 or 11).
  function automatic logic dr_bad(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] a_n);
    return |(a ~^ a_n);
  endfunction

endpackage

// File: rtl/wddl_xor128.sv
// Purely combinational 128-bit dual-rail XOR in positive WDDL form
// (only AND/OR gates, so a precharged 0/0 input yields a 0/0 output).
module wddl_xor128
  import aes_wddl_pkg::*;
(
  input  logic [BLK_W-1:0] i_a,
  input  logic [BLK_W-1:0] i_a_n,
  input  logic [BLK_W-1:0] i_b,
  input  logic [BLK_W-1:0] i_b_n,
  output logic [BLK_W-1:0] o_y,
  output logic [BLK_W-1:0] o_y_n
);

  assign o_y   = (i_a & i_b_n) | (i_a_n & i_b);
  assign o_y_n = (i_a & i_b)   | (i_a_n & i_b_n);

endmodule

// File: rtl/aes_inv_addroundkey_wddl.sv
// Inverse-cipher key-addition sequencer: loads ciphertext^key, then runs
// NR precharge/evaluate rounds folding the external datapath result with kw.
module aes_inv_addroundkey_wddl
  import aes_wddl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BLK_W-1:0] text_in,
  input  logic [BLK_W-1:0] text_in_n,
  input  logic [BLK_W-1:0] kw,
  input  logic [BLK_W-1:0] kw_n,
  input  logic [BLK_W-1:0] sa_in,
  input  logic [BLK_W-1:0] sa_in_n,
  output logic [BLK_W-1:0] sa_next,
  output logic [BLK_W-1:0] sa_next_n,
  output logic             ph,
  output logic             busy,
  output logic [3:0]       kcnt,
  output logic             done,
  output logic             err
);

  state_e           r_st, w_st_nxt;
  logic [BLK_W-1:0] r_sa, r_sa_n;
  logic [3:0]       r_kcnt;
  logic             r_err;
  logic [BLK_W-1:0] w_ld_sa, w_ld_sa_n, w_ev_sa, w_ev_sa_n;
  logic             w_load, w_ld_viol, w_ev_viol;

  wddl_xor128 u_xor_load (
    .i_a   (text_in),
    .i_a_n (text_in_n),
    .i_b   (kw),
    .i_b_n (kw_n),
    .o_y   (w_ld_sa),
    .o_y_n (w_ld_sa_n)
  );

  wddl_xor128 u_xor_eval (
    .i_a   (sa_in),
    .i_a_n (sa_in_n),
    .i_b   (kw),
    .i_b_n (kw_n),
    .o_y   (w_ev_sa),
    .o_y_n (w_ev_sa_n)
  );

  assign w_load    = (r_st == IDLE) && ld;
  assign w_ld_viol = dr_bad(text_in, text_in_n) | dr_bad(kw, kw_n);
  assign w_ev_viol = dr_bad(sa_in, sa_in_n) | dr_bad(kw, kw_n);

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      IDLE:    if (ld) w_st_nxt = PRE;
      PRE:     w_st_nxt = EVAL;
      EVAL:    w_st_nxt = (r_kcnt == '0) ? DONE : PRE;
      DONE:    w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  // A violation on the load edge replaces the old flag, so it wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= IDLE;
      r_sa   <= '0;
      r_sa_n <= '0;
      r_kcnt <= KCNT_IDLE;
      r_err  <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_load) begin
        r_sa   <= w_ld_sa;
        r_sa_n <= w_ld_sa_n;
        r_kcnt <= KCNT_FIRST;
        r_err  <= w_ld_viol;
      end else if (r_st == EVAL) begin
        r_sa   <= w_ev_sa;
        r_sa_n <= w_ev_sa_n;
        r_err  <= r_err | w_ev_viol;
        if (r_kcnt != '0) r_kcnt <= r_kcnt - 4'd1;
      end else if (r_st == DONE) begin
        r_kcnt <= KCNT_IDLE;
      end
    end
  end

  assign ph        = (r_st == EVAL);
  assign done      = (r_st == DONE);
  assign busy      = (r_st != IDLE);
  assign kcnt      = r_kcnt;
  assign err       = r_err;
  assign sa_next   = (ph || done) ? r_sa   : '0;
  assign sa_next_n = (ph || done) ? r_sa_n : '0;

endmodule

// File: tb/tb_aes_inv_addroundkey_wddl.sv
// Scenario bench for aes_inv_addroundkey_wddl with a dual-rail expected-state queue.
module tb_aes_inv_addroundkey_wddl;
  import aes_wddl_pkg::*;

  logic         clk = 1'b0;
  logic         rst, ld;
  logic [127:0] text_in, text_in_n, kw, kw_n, sa_in, sa_in_n;
  logic [127:0] sa_next, sa_next_n;
  logic         ph, busy, done, err;
  logic [3:0]   kcnt;

  typedef struct packed {
    logic [127:0] v;
    logic [127:0] vn;
  } dr_t;

  dr_t exp_q[$];
  dr_t e;
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  aes_inv_addroundkey_wddl dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .text_in   (text_in),
    .text_in_n (text_in_n),
    .kw        (kw),
    .kw_n      (kw_n),
    .sa_in     (sa_in),
    .sa_in_n   (sa_in_n),
    .sa_next   (sa_next),
    .sa_next_n (sa_next_n),
    .ph        (ph),
    .busy      (busy),
    .kcnt      (kcnt),
    .done      (done),
    .err       (err)
  );

  function automatic dr_t dx(input logic [127:0] a, a_n, b, b_n);
    dr_t r;
    r.v  = (a & b_n) | (a_n & b);
    r.vn = (a & b) | (a_n & b_n);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ld(input logic [127:0] t, input logic [127:0] k);
    text_in = t; text_in_n = ~t; kw = k; kw_n = ~k; ld = 1'b1;
    exp_q.push_back(dx(t, ~t, k, ~k));
  endtask

  task automatic drive_eval(input logic [127:0] s, input logic [127:0] k, input int bad_bit);
    sa_in = s; sa_in_n = ~s; kw = k; kw_n = ~k;
    if (bad_bit >= 0) begin
      sa_in[bad_bit]   = 1'b1;
      sa_in_n[bad_bit] = 1'b1;
    end
    exp_q.push_back(dx(sa_in, sa_in_n, kw, kw_n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0;
    #2 rst = 1'b0; ld = 1'b1;
    tick(); tick();
    n_chk++;
    if ({sa_next, sa_next_n, ph, busy, kcnt, done, err} !== {256'h0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: ph=%b busy=%b kcnt=%0d done=%b err=%b sa=%h/%h required 0 0 10 0 0 zeros",
               ph, busy, kcnt, done, err, sa_next, sa_next_n);
    end
    ld = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if ({busy, kcnt} !== {1'b0, 4'd10}) begin
      n_fail++;
      $display("FAIL reset_no_start: busy=%b kcnt=%0d required 0 10", busy, kcnt);
    end
  endtask

  task automatic test_load();
    exp_q.delete();
    drive_ld(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    tick(); ld = 1'b0;
    n_chk++;
    if ({ph, busy, sa_next, sa_next_n} !== {1'b0, 1'b1, 256'h0}) begin
      n_fail++;
      $display("FAIL load_precharge: ph=%b busy=%b sa=%h/%h required 0 1 zeros", ph, busy, sa_next, sa_next_n);
    end
    tick();
    n_chk++;
    if ({ph, sa_next, sa_next_n, err, kcnt} !==
        {1'b1, 128'h00102030405060708090a0b0c0d0e0f0, ~128'h00102030405060708090a0b0c0d0e0f0, 1'b0, 4'd9}) begin
      n_fail++;
      $display("FAIL load_value: ph=%b sa=%h/%h err=%b kcnt=%0d required 1 00102030405060708090a0b0c0d0e0f0/complement 0 9",
               ph, sa_next, sa_next_n, err, kcnt);
    end
    void'(exp_q.pop_front());
    drive_eval(rnd128(), rnd128(), -1);
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (ph || done) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_sb: output at step %0d with no expected value", k);
        end else begin
          e = exp_q.pop_front();
          if ({sa_next, sa_next_n} !== e) begin
            n_fail++;
            $display("FAIL load_sb: step %0d sa=%h/%h required %h/%h", k, sa_next, sa_next_n, e.v, e.vn);
          end
        end
      end
      if (ph) drive_eval(rnd128(), rnd128(), -1);
    end
    tick();
    n_chk++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end: busy=%b pending=%0d required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_full_sequence();
    exp_q.delete();
    drive_ld(rnd128(), '0);
    tick(); ld = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k < 20 && k % 2 == 0) begin
        n_chk++;
        if ({ph, busy, done, sa_next, sa_next_n} !== {3'b010, 256'h0}) begin
          n_fail++;
          $display("FAIL full_pre: step %0d ph=%b busy=%b done=%b sa=%h/%h required 0 1 0 zeros",
                   k, ph, busy, done, sa_next, sa_next_n);
        end
      end else begin
        n_chk++;
        if ({ph, busy, done, kcnt} !== ((k == 20) ? {3'b011, 4'd0} : {3'b110, 4'(9 - (k - 1) / 2)})) begin
          n_fail++;
          $display("FAIL full_ctl: step %0d ph=%b busy=%b done=%b kcnt=%0d required kcnt=%0d done=%0d",
                   k, ph, busy, done, kcnt, (k == 20) ? 0 : 9 - (k - 1) / 2, k == 20);
        end
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL full_sb: step %0d no expected value", k);
        end else begin
          e = exp_q.pop_front();
          if ({sa_next, sa_next_n} !== e) begin
            n_fail++;
            $display("FAIL full_sb: step %0d sa=%h/%h required %h/%h", k, sa_next, sa_next_n, e.v, e.vn);
          end
        end
        if (k < 20) drive_eval('0, '0, -1);
      end
      tick();
    end
    n_chk++;
    if ({ph, busy, done, kcnt, sa_next, sa_next_n} !== {3'b000, 4'd10, 256'h0}) begin
      n_fail++;
      $display("FAIL full_idle: ph=%b busy=%b done=%b kcnt=%0d required 0 0 0 10", ph, busy, done, kcnt);
    end
  endtask

  task automatic test_violation();
    exp_q.delete();
    drive_ld(rnd128(), rnd128());
    tick(); ld = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      n_chk++;
      if (err !== (k >= 6)) begin
        n_fail++;
        $display("FAIL viol_err: step %0d err=%b required %0d", k, err, k >= 6);
      end
      if (ph || done) begin
        n_chk++;
        e = exp_q.pop_front();
        if ({sa_next, sa_next_n} !== e) begin
          n_fail++;
          $display("FAIL viol_sb: step %0d sa=%h/%h required %h/%h", k, sa_next, sa_next_n, e.v, e.vn);
        end
      end
      if (ph) drive_eval(rnd128(), rnd128(), ((k + 1) / 2 == 3) ? 5 : -1);
      if (k < 21) tick();
    end
    drive_ld(rnd128(), rnd128());
    text_in_n[0] = text_in[0];
    tick(); ld = 1'b0;
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_ld_wins: err=%b required 1", err);
    end
    wait_idle();
    drive_ld(rnd128(), rnd128());
    tick(); ld = 1'b0;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_clear: err=%b required 0", err);
    end
    wait_idle();
  endtask

  task automatic test_ld_ignored_and_reset();
    logic [127:0] s, k0;
    int cnt;
    s = rnd128(); k0 = rnd128();
    exp_q.delete();
    drive_ld(rnd128(), k0);
    exp_q.delete();
    sa_in = s; sa_in_n = ~s;
    exp_q.push_back(dx(s, ~s, k0, ~k0));
    tick();
    for (int k = 0; k <= 20; k++) begin
      ld = (k <= 1 || k == 20);
      n_chk++;
      if (done !== (k == 20)) begin
        n_fail++;
        $display("FAIL ign_done: step %0d done=%b required %0d", k, done, k == 20);
      end
      if (k == 20) begin
        n_chk++;
        e = exp_q.pop_front();
        if ({sa_next, sa_next_n} !== e) begin
          n_fail++;
          $display("FAIL ign_sb: sa=%h/%h required %h/%h", sa_next, sa_next_n, e.v, e.vn);
        end
      end
      tick();
    end
    ld = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_restart: busy=%b required 0", busy);
    end
    drive_ld(rnd128(), rnd128());
    text_in_n[7] = text_in[7];
    tick(); ld = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    n_chk++;
    if ({ph, err, kcnt} !== {1'b1, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL rst_pre: ph=%b err=%b kcnt=%0d required 1 1 5", ph, err, kcnt);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({sa_next, sa_next_n, ph, busy, kcnt, done, err} !== {256'h0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: ph=%b busy=%b kcnt=%0d done=%b err=%b sa=%h/%h required 0 0 10 0 0 zeros",
               ph, busy, kcnt, done, err, sa_next, sa_next_n);
    end
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    exp_q.delete();
    drive_ld(rnd128(), k0);
    exp_q.delete();
    exp_q.push_back(dx(s, ~s, k0, ~k0));
    tick(); ld = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      tick();
      cnt++;
    end
    n_chk++;
    if (cnt != 20) begin
      n_fail++;
      $display("FAIL rst_rerun_len: done after %0d cycles required 20", cnt);
    end
    n_chk++;
    e = exp_q.pop_front();
    if ({sa_next, sa_next_n} !== e) begin
      n_fail++;
      $display("FAIL rst_rerun_sb: sa=%h/%h required %h/%h", sa_next, sa_next_n, e.v, e.vn);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld = 1'b0;
    text_in = '0; text_in_n = '1; kw = '0; kw_n = '1; sa_in = '0; sa_in_n = '1;
    test_reset();
    test_load();
    test_full_sequence();
    test_violation();
    test_ld_ignored_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
